// File: rtl/simple_gc_pkg.sv
// ============================================================================
// Module  : simple_gc_pkg
// Brief   : Shared defaults and helpers for simple_gated_counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package simple_gc_pkg;

    localparam int SIMPLE_GC_CH_DEF     = 4;
    localparam int SIMPLE_GC_CNT_W_DEF  = 3;
    localparam int SIMPLE_GC_STAGES_DEF = 2;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/simple_gc_chan.sv
// ============================================================================
// Module  : simple_gc_chan
// Brief   : One channel: AND gate, hold-priority counter, raw nz/wrap flags.
//           SIMPLE_GC_SAT_EN selects saturate-at-max instead of modulo wrap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module simple_gc_chan
    import simple_gc_pkg::*;
#(
    parameter int CNT_W = SIMPLE_GC_CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inp1_i,
    input  logic             inp2_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nz_o,
    output logic             wr_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic             w_gate;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;

    assign w_gate = inp1_i & inp2_i;

    always_comb begin
        cnt_d = cnt_q;
        wr_d  = 1'b0;
        if (hold_i) begin
            cnt_d = cnt_q;
        end else if (w_gate) begin
`ifdef SIMPLE_GC_SAT_EN
            // Pulse only on the step that lands on max; stay there afterwards.
            if (cnt_q != c_CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
                wr_d  = ((cnt_q + CNT_W'(1)) == c_CNT_MAX);
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
            wr_d  = (cnt_q == c_CNT_MAX);
`endif
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nz_o  = (cnt_q != '0);
    assign wr_o  = wr_q;

endmodule

`default_nettype wire

// File: rtl/simple_gated_counter.sv
// ============================================================================
// Module  : simple_gated_counter
// Brief   : CH gated modulo counters with a STAGES-deep nz/wrap output pipe.
//           Optional SIMPLE_GC_SAT_EN makes counters saturate at max.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module simple_gated_counter
    import simple_gc_pkg::*;
#(
    parameter int CH     = SIMPLE_GC_CH_DEF,
    parameter int CNT_W  = SIMPLE_GC_CNT_W_DEF,
    parameter int STAGES = SIMPLE_GC_STAGES_DEF
) (
    input  logic                tau2015_clk,
    input  logic                tau2015_rst_n,
    input  logic [CH-1:0]       inp1,
    input  logic [CH-1:0]       inp2,
    input  logic [CH-1:0]       hold,
    output logic [CH-1:0]       out,
    output logic [CH-1:0]       wrap,
    output logic [CH*CNT_W-1:0] cnt_o
);

    logic [CH-1:0] w_nz;
    logic [CH-1:0] w_wr;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        simple_gc_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i   (tau2015_clk),
            .rst_n_i (tau2015_rst_n),
            .inp1_i  (inp1[c]),
            .inp2_i  (inp2[c]),
            .hold_i  (hold[c]),
            .cnt_o   (cnt_o[c*CNT_W +: CNT_W]),
            .nz_o    (w_nz[c]),
            .wr_o    (w_wr[c])
        );
    end

    if (STAGES == 0) begin : g_no_pipe
        assign out  = w_nz;
        assign wrap = w_wr;
    end else begin : g_pipe
        logic [CH-1:0] nz_pipe_q [STAGES];
        logic [CH-1:0] wr_pipe_q [STAGES];

        // Free-running shift: hold freezes counters, never the pipe.
        always_ff @(negedge tau2015_clk or negedge tau2015_rst_n) begin
            if (!tau2015_rst_n) begin
                for (int s = 0; s < STAGES; s++) begin
                    nz_pipe_q[s] <= '0;
                    wr_pipe_q[s] <= '0;
                end
            end else begin
                nz_pipe_q[0] <= w_nz;
                wr_pipe_q[0] <= w_wr;
                for (int s = 1; s < STAGES; s++) begin
                    nz_pipe_q[s] <= nz_pipe_q[s-1];
                    wr_pipe_q[s] <= wr_pipe_q[s-1];
                end
            end
        end

        assign out  = nz_pipe_q[STAGES-1];
        assign wrap = wr_pipe_q[STAGES-1];
    end

endmodule

`default_nettype wire

// File: doc/simple_gated_counter.md
# simple_gated_counter

Parametrised multi-channel successor to the single-bit gated toggle cell of the `simple` timing benchmarks. Each channel ANDs two enable inputs and uses the result to gate a modulo counter: the counter advances while gated, clears when ungated, and can be frozen. The block emits a registered nonzero flag and a wrap pulse per channel through a configurable output pipeline. It sits wherever the benchmark netlists need scalable sequential paths driven from `tau2015_clk`.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `CNT_W`, 3: counter width per channel (≥1; `CNT_W=1` is the legacy toggle behaviour).
- `STAGES`, 2: output pipeline depth on `out` and `wrap` (≥0; 0 means the outputs are combinational from the counter state).
- `tau2015_clk` input 1: single clock; all state updates on its **falling** edge.
- `tau2015_rst_n` input 1: asynchronous, active-low reset.
- `inp1` input CH: per-channel enable A.
- `inp2` input CH: per-channel enable B.
- `hold` input CH: per-channel freeze; has priority over the gate.
- `out` output CH: per-channel flag, `cnt != 0`, delayed by `STAGES`.
- `wrap` output CH: per-channel one-cycle pulse on counter wrap (or saturation; see Configuration), delayed by `STAGES`.
- `cnt_o` output CH*CNT_W: raw counter values, channel c at bits `[c*CNT_W +: CNT_W]`, not pipelined.

## Operation
- Gate per channel: `g[c] = inp1[c] & inp2[c]`.
- Update priority per channel, at each falling edge:
  - `hold[c]=1`: `cnt` keeps its value.
  - `g[c]=1`: `cnt <= cnt+1`, computed modulo 2^CNT_W.
  - Otherwise: `cnt <= 0`.
- Wrap event: `g=1`, `hold=0` and `cnt == 2^CNT_W-1`. The next `cnt` is 0 and the raw wrap flag is 1 for that cycle.
- Raw flags feed the pipeline:
  - `nz[c] = (cnt[c] != 0)`, taken from the registered counter.
  - `wr[c]` is registered together with the counter update.
- Pipeline: `STAGES` falling-edge registers per channel for both `nz` and `wr`. No enable or stall; the pipeline always shifts, including while `hold` is high.
- Channels are fully independent. No cross-channel logic.

## Timing
- Reset (asynchronous assert, any time):
  - All `cnt` = 0; `cnt_o` = 0.
  - All pipeline registers = 0; `out` = 0 and `wrap` = 0 immediately.
- Reset release: the first update happens at the first falling edge after `tau2015_rst_n` rises.
- Reset mid-count: state is lost and the counter restarts from 0. No wrap pulse is produced.
- Latency:
  - `cnt_o` changes at falling edge N.
  - `out` and `wrap` reflect edge N's state at edge N+STAGES.
  - With `STAGES=0`, `out` and `wrap` track `cnt` combinationally after edge N.
- `wrap` is high for exactly one clock period per wrap event.
- Back-to-back wraps are impossible for `CNT_W≥2`. With `CNT_W=1`, a wrap occurs every second gated cycle.
- Simultaneous `hold=1` and `g=1`: hold wins, with no count and no wrap.
- `g` toggling every cycle: the counter alternates between 1 and 0.

## Configuration
- `SIMPLE_GC_SAT_EN` defined:
  - The counter saturates at 2^CNT_W-1 instead of wrapping.
  - `wrap` becomes a pulse on the cycle `cnt` first reaches max.
  - Further gated cycles hold at max and produce no further pulse.
  - An ungated cycle clears to 0 as usual.
- `SIMPLE_GC_SAT_EN` undefined: modulo wrap behaviour as described above.

## Structure
- Package `simple_gc_pkg` holds:
  - Default parameter constants `SIMPLE_GC_CH_DEF`, `SIMPLE_GC_CNT_W_DEF`, `SIMPLE_GC_STAGES_DEF`.
  - Function `cnt_max(width)` returning 2^width-1.
- Sub-module `simple_gc_chan`: one channel's gate, counter, hold logic and raw `nz`/`wr` flags. It is instantiated CH times via generate.
- The top level owns the `STAGES`-deep shift pipeline and the `cnt_o` packing.

## Test plan
- Reset: assert `tau2015_rst_n=0` mid-count with `cnt=5` -> `cnt_o`, `out` and `wrap` all 0 asynchronously, before the next edge.
- Count and wrap (CH=4, CNT_W=3, STAGES=2): `inp1=inp2=4'b0001` for 9 falling edges -> `cnt_o[2:0]` reads 1..7, 0, 1. `wrap[0]` pulses once, 2 edges after `cnt` goes 7→0. `out[0]` is 0 exactly during that zero cycle (delayed by 2).
- Clear: after `cnt=3`, drop `inp2[0]` for 1 edge -> `cnt=0`; `out[0]` falls 2 edges later; no `wrap`.
- Hold priority: `cnt=6`, `hold[0]=1` with `g=1` for 4 edges -> `cnt` stays 6 and `wrap` stays 0. Releasing hold then gives 7, then 0 with a `wrap` pulse.
- Channel independence: gate channel 2 only, and hold channel 1 at `cnt=2` -> channels 0 and 3 stay 0, channel 1 stays 2, channel 2 counts.
- `SIMPLE_GC_SAT_EN` defined, 10 gated edges -> `cnt` stops at 7 with a single `wrap` pulse; one ungated edge -> `cnt=0`.
